// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dcache_ctrl
// Brief    : 8-line direct-mapped, 4-word-line, write-back/write-allocate
//            data cache controller with zero-latency hits.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
);

  localparam int         NUM_LINES   = 8;
  localparam logic [1:0] S_COMPARE   = 2'd0;
  localparam logic [1:0] S_WRITEBACK = 2'd1;
  localparam logic [1:0] S_ALLOCATE  = 2'd2;
  localparam logic [1:0] S_REFILL    = 2'd3;

  logic [1:0]           state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [24:0]          tag_q  [NUM_LINES];
  logic [127:0]         data_q [NUM_LINES];

  logic [2:0]   w_index;
  logic [1:0]   w_offset;
  logic [24:0]  w_tag;
  logic [6:0]   w_bitpos;
  logic         w_req;
  logic         w_hit;
  logic [127:0] w_line;
  logic [31:0]  w_word;
  logic [127:0] w_line_merged;
  logic         w_alloc_done;
  logic         w_write_hit;

  assign w_index      = proc_addr[4:2];
  assign w_offset     = proc_addr[1:0];
  assign w_tag        = proc_addr[29:5];
  assign w_bitpos     = {w_offset, 5'b00000};
  assign w_req        = proc_read | proc_write;
  assign w_hit        = valid_q[w_index] && (tag_q[w_index] == w_tag);
  assign w_line       = data_q[w_index];
  assign w_word       = w_line[w_bitpos +: 32];
  assign w_alloc_done = (state_q == S_ALLOCATE) && mem_ready;
  // A simultaneous read+write is serviced as a store.
  assign w_write_hit  = (state_q == S_COMPARE) && proc_write && w_hit;

  always_comb begin
    w_line_merged = w_line;
    w_line_merged[w_bitpos +: 32] = proc_wdata;
  end

  // State and line status bits; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COMPARE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_COMPARE: begin
        if (w_req && !w_hit) begin
          state_d = (valid_q[w_index] && dirty_q[w_index]) ? S_WRITEBACK : S_ALLOCATE;
        end
      end
      S_WRITEBACK: if (mem_ready) state_d = S_ALLOCATE;
      S_ALLOCATE:  if (mem_ready) state_d = S_REFILL;
      S_REFILL:    state_d = S_COMPARE;
      default:     state_d = S_COMPARE;
    endcase
  end

  always_comb begin
    proc_stall = 1'b1;
    proc_rdata = '0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = proc_addr[29:2];
    mem_wdata  = w_line;
    case (state_q)
      S_COMPARE: begin
        proc_stall = w_req && !w_hit;
        if (proc_read && !proc_write && w_hit) proc_rdata = w_word;
      end
      S_WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {tag_q[w_index], w_index};
      end
      S_ALLOCATE: mem_read = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (w_alloc_done) begin
      valid_d[w_index] = 1'b1;
      dirty_d[w_index] = 1'b0;
    end
    if (w_write_hit) dirty_d[w_index] = 1'b1;
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_alloc_done) begin
      data_q[w_index] <= mem_rdata;
      tag_q[w_index]  <= w_tag;
    end else if (w_write_hit) begin
      data_q[w_index] <= w_line_merged;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_ctrl
// Brief    : Directed and random self-checking bench for dcache_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  logic         auto_mem;
  logic         a_ready, d_ready;
  logic [127:0] a_rdata, d_rdata;
  int           lat_cnt;
  int           both_err;
  int           n_pass;
  int           n_total;

  logic [127:0] mem  [64];
  logic [31:0]  refm [256];

  localparam logic [31:0] WA = 32'hAAAA0000, WB = 32'hBBBB0001, WC = 32'hCCCC0002, WD = 32'hDDDD0003;
  localparam logic [31:0] WE = 32'hEEEE0004, WF = 32'hFFFF0005, WG = 32'h11110006, WH = 32'h22220007;
  localparam logic [31:0] K0 = 32'h30303030, K1 = 32'h31313131, K2 = 32'h32323232, K3 = 32'h33333333;

  assign mem_ready = auto_mem ? a_ready : d_ready;
  assign mem_rdata = auto_mem ? a_rdata : d_rdata;

  dcache_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random-latency memory responder, also watches for read/write overlap.
  always @(negedge clk) begin
    if (mem_read && mem_write) both_err++;
    if (a_ready) begin
      a_ready = 1'b0;
      lat_cnt = 0;
    end else if (auto_mem && (mem_read || mem_write)) begin
      if (lat_cnt == 0) lat_cnt = int'($urandom_range(1, 20));
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        a_ready = 1'b1;
        if (mem_write) mem[mem_addr[5:0]] = mem_wdata;
        else           a_rdata = mem[mem_addr[5:0]];
      end
    end
  end

  task automatic drive(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] wd);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
  endtask

  // Called at a negedge: presents mem_ready for one rising edge, returns at the next negedge.
  task automatic pulse_ready(input logic [127:0] blk);
    d_ready = 1'b1;
    d_rdata = blk;
    @(posedge clk); #1;
    d_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    #1;
    n_total++; if (proc_stall !== 1'b0) $display("FAIL reset_idle_stall: got %b want 0", proc_stall); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL reset_mem_read: got %b want 0", mem_read); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL reset_mem_write: got %b want 0", mem_write); else n_pass++;
    n_total++; if (proc_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", proc_rdata); else n_pass++;
    drive(1'b1, 1'b0, 30'h10, 32'h0);
    #1;
    n_total++; if (proc_stall !== 1'b1) $display("FAIL reset_req_stall: got %b want 1", proc_stall); else n_pass++;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_refill();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h10, 32'h0);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b1) $display("FAIL miss_stall: got %b want 1", proc_stall); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL miss_cmp_mem_read: got %b want 0", mem_read); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_read !== 1'b1) $display("FAIL alloc_mem_read: got %b want 1", mem_read); else n_pass++;
    n_total++; if (mem_write !== 1'b0) $display("FAIL alloc_mem_write: got %b want 0", mem_write); else n_pass++;
    n_total++; if (mem_addr !== 28'h4) $display("FAIL alloc_addr: got %h want 0000004", mem_addr); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_read !== 1'b1) $display("FAIL alloc_hold: got %b want 1", mem_read); else n_pass++;
    pulse_ready({WD, WC, WB, WA});
    n_total++; if (proc_stall !== 1'b1) $display("FAIL refill_stall: got %b want 1", proc_stall); else n_pass++;
    n_total++; if (mem_read !== 1'b0) $display("FAIL refill_mem_read: got %b want 0", mem_read); else n_pass++;
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0) $display("FAIL refill_done_stall: got %b want 0", proc_stall); else n_pass++;
    n_total++; if (proc_rdata !== WA) $display("FAIL refill_rdata: got %h want %h", proc_rdata, WA); else n_pass++;
  endtask

  task automatic test_write_hit();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 30'h11, 32'hDEADBEEF);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0) $display("FAIL whit_stall: got %b want 0", proc_stall); else n_pass++;
    n_total++; if (proc_rdata !== 32'h0) $display("FAIL whit_rdata: got %h want 0", proc_rdata); else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h11, 32'h0);
    @(negedge clk);
    n_total++; if (proc_rdata !== 32'hDEADBEEF || proc_stall !== 1'b0) $display("FAIL whit_readback: got %h/%b want deadbeef/0", proc_rdata, proc_stall); else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h12, 32'h0);
    @(negedge clk);
    n_total++; if (proc_rdata !== WC) $display("FAIL whit_other_word: got %h want %h", proc_rdata, WC); else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 30'h13, 32'h00000055);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) $display("FAIL rw_as_write: got %b/%h want 0/0", proc_stall, proc_rdata); else n_pass++;
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 30'h111, 32'h0);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0 || proc_rdata !== 32'h0) $display("FAIL idle: got %b/%h want 0/0", proc_stall, proc_rdata); else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h13, 32'h0);
    @(negedge clk);
    n_total++; if (proc_rdata !== 32'h55) $display("FAIL rw_readback: got %h want 00000055", proc_rdata); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h111, 32'h0);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b1 || mem_write !== 1'b0) $display("FAIL evict_cmp: got %b/%b want 1/0", proc_stall, mem_write); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL wb_strobes: got w%b r%b want w1 r0", mem_write, mem_read); else n_pass++;
    n_total++; if (mem_addr !== 28'h4) $display("FAIL wb_addr: got %h want 0000004", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== {32'h55, WC, 32'hDEADBEEF, WA}) $display("FAIL wb_data: got %h want %h", mem_wdata, {32'h55, WC, 32'hDEADBEEF, WA}); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_write !== 1'b1) $display("FAIL wb_hold: got %b want 1", mem_write); else n_pass++;
    pulse_ready(128'h0);
    n_total++; if (mem_read !== 1'b1 || mem_write !== 1'b0) $display("FAIL wb_to_alloc: got r%b w%b want r1 w0", mem_read, mem_write); else n_pass++;
    n_total++; if (mem_addr !== 28'h44) $display("FAIL evict_alloc_addr: got %h want 0000044", mem_addr); else n_pass++;
    pulse_ready({WH, WG, WF, WE});
    n_total++; if (proc_stall !== 1'b1) $display("FAIL evict_refill_stall: got %b want 1", proc_stall); else n_pass++;
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0 || proc_rdata !== WF) $display("FAIL evict_rdata: got %b/%h want 0/%h", proc_stall, proc_rdata, WF); else n_pass++;
  endtask

  task automatic test_store_miss();
    logic [31:0] exp_w [4];
    exp_w[0] = K0; exp_w[1] = K1; exp_w[2] = 32'h12345678; exp_w[3] = K3;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 30'h22, 32'h12345678);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b1) $display("FAIL smiss_stall: got %b want 1", proc_stall); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h8) $display("FAIL smiss_alloc: got r%b w%b a%h want r1 w0 a0000008", mem_read, mem_write, mem_addr); else n_pass++;
    pulse_ready({K3, K2, K1, K0});
    n_total++; if (proc_stall !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL smiss_refill: got s%b r%b w%b want s1 r0 w0", proc_stall, mem_read, mem_write); else n_pass++;
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0) $display("FAIL smiss_merge_stall: got %b want 0", proc_stall); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 30'h20 + 30'(i), 32'h0);
      @(negedge clk);
      n_total++; if (proc_rdata !== exp_w[i]) $display("FAIL smiss_word%0d: got %h want %h", i, proc_rdata, exp_w[i]); else n_pass++;
    end
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h40, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_total++; if (mem_write !== 1'b1 || mem_addr !== 28'h8) $display("FAIL smiss_dirty_wb: got w%b a%h want w1 a0000008", mem_write, mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== {K3, 32'h12345678, K1, K0}) $display("FAIL smiss_wb_data: got %h want %h", mem_wdata, {K3, 32'h12345678, K1, K0}); else n_pass++;
    pulse_ready(128'h0);
    n_total++; if (mem_addr !== 28'h10) $display("FAIL smiss_alloc2_addr: got %h want 0000010", mem_addr); else n_pass++;
    pulse_ready(128'h0);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0) $display("FAIL smiss_final_stall: got %b want 0", proc_stall); else n_pass++;
  endtask

  task automatic test_reset_mid_alloc();
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h111, 32'h0);
    @(negedge clk);
    n_total++; if (proc_stall !== 1'b0 || proc_rdata !== WF) $display("FAIL rst_pre_hit: got %b/%h want 0/%h", proc_stall, proc_rdata, WF); else n_pass++;
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 30'h31, 32'h0);
    @(negedge clk);
    @(negedge clk);
    n_total++; if (mem_read !== 1'b1) $display("FAIL rst_alloc_active: got %b want 1", mem_read); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL rst_async_drop: got r%b w%b want r0 w0", mem_read, mem_write); else n_pass++;
    n_total++; if (proc_stall !== 1'b1) $display("FAIL rst_stall_inputs: got %b want 1", proc_stall); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 30'h111, 32'h0);
    #1;
    n_total++; if (proc_stall !== 1'b1) $display("FAIL rst_prior_misses: got %b want 1", proc_stall); else n_pass++;
    @(negedge clk);
    n_total++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 28'h44) $display("FAIL rst_clean_refetch: got r%b w%b a%h want r1 w0 a0000044", mem_read, mem_write, mem_addr); else n_pass++;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [29:0] a;
    logic [31:0] wd;
    int          kind;
    int          n;
    for (int b = 0; b < 64; b++) begin
      for (int k = 0; k < 4; k++) begin
        w = $urandom;
        mem[b][k*32 +: 32] = w;
        refm[b*4 + k] = w;
      end
    end
    auto_mem = 1'b1;
    for (int op = 0; op < 150; op++) begin
      kind = int'($urandom_range(0, 9));
      a    = 30'($urandom_range(0, 255));
      wd   = $urandom;
      @(posedge clk); #1;
      if (kind == 0)      drive(1'b0, 1'b0, a, wd);
      else if (kind <= 5) drive(1'b1, 1'b0, a, wd);
      else if (kind <= 8) drive(1'b0, 1'b1, a, wd);
      else                drive(1'b1, 1'b1, a, wd);
      @(negedge clk);
      n = 0;
      while (proc_stall && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (proc_stall) begin
        n_total++;
        $display("FAIL rand_timeout: op %0d still stalled after %0d cycles, want 0", op, n);
        break;
      end else if (proc_write) begin
        refm[a[7:0]] = wd;
      end else if (proc_read) begin
        n_total++; if (proc_rdata !== refm[a[7:0]]) $display("FAIL rand_load: op %0d addr %h got %h want %h", op, a, proc_rdata, refm[a[7:0]]); else n_pass++;
      end else begin
        n_total++; if (n !== 0) $display("FAIL rand_idle_stall: op %0d stalled %0d cycles want 0", op, n); else n_pass++;
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    @(negedge clk);
    n_total++; if (both_err !== 0) $display("FAIL rw_overlap: got %0d cycles want 0", both_err); else n_pass++;
  endtask

  initial begin
    n_pass   = 0;
    n_total  = 0;
    both_err = 0;
    lat_cnt  = 0;
    auto_mem = 1'b0;
    a_ready  = 1'b0;
    d_ready  = 1'b0;
    a_rdata  = '0;
    d_rdata  = '0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 30'h0, 32'h0);
    repeat (2) @(posedge clk);
    test_reset();
    test_refill();
    test_write_hit();
    test_dirty_evict();
    test_store_miss();
    test_reset_mid_alloc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
`default_nettype wire
